// File: rtl/pixel_dispatcher_pkg.sv
// ---------------------------------------------------------------------------
// pixel_dispatcher_pkg
//   Shared types for the pixel dispatcher and its coordinate FIFO:
//     fp       - signed 16-bit fixed-point scalar (vector arithmetic type)
//     vec3     - packed {x, y, z} vector of fp
//     state_t  - dispatcher FSM state (IDLE / ISSUE / DRAIN)
//   Also provides fallback values for the display geometry macros
//   `DISPLAY_WIDTH, `DISPLAY_HEIGHT, `H_BITS and `V_BITS. These are the
//   default parameter values of pixel_dispatcher when no override is given.
//   Optional feature macro: INTERLACE_EN (consumed by pixel_dispatcher).
// ---------------------------------------------------------------------------
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 640
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 480
`endif
`ifndef H_BITS
`define H_BITS 10
`endif
`ifndef V_BITS
`define V_BITS 10
`endif

package pixel_dispatcher_pkg;

    localparam int FP_W = 16;

    typedef logic signed [FP_W-1:0] fp;

    typedef struct packed {
        fp x;
        fp y;
        fp z;
    } vec3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_dispatcher_coord_fifo.sv
// ---------------------------------------------------------------------------
// pixel_dispatcher_coord_fifo
//   Synchronous FIFO holding the {hcount, vcount} tags of pixels that are in
//   flight inside the ray generator. The head is read combinationally, so a
//   pop and the use of the popped tag happen in the same cycle.
//   Ports:
//     i_clk, i_rst_n     - clock, synchronous active-low reset
//     i_push, i_push_data- write one tag (ignored when full)
//     i_pop              - drop the head entry (ignored when empty)
//     o_head             - current head entry
//     o_empty, o_full    - occupancy flags
//     o_count            - occupancy, $clog2(DEPTH+1) bits
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module pixel_dispatcher_coord_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_push,
    input  logic [DATA_W-1:0]                i_push_data,
    input  logic                             i_pop,
    output logic [DATA_W-1:0]                o_head,
    output logic                             o_empty,
    output logic                             o_full,
    output logic [$clog2(DEPTH+1)-1:0]       o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Simultaneous push and pop leave the occupancy unchanged.
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_count = r_count;

endmodule

// File: rtl/pixel_dispatcher.sv
// ---------------------------------------------------------------------------
// pixel_dispatcher
//   Walks a frame in raster order and issues one pixel coordinate at a time
//   to the ray generator, together with a camera forward vector latched at
//   frame start. Issued coordinates are queued; each ray direction returned
//   by the generator is re-tagged with the head coordinate and forwarded to
//   the ray marcher one cycle later.
//
//   Handshake: gen_valid_out is a registered one-cycle pulse. A pixel is
//   issued at a clock edge where the FSM is in ISSUE, gen_ready_in = 1, no
//   pulse is currently out (gen_valid_out = 0) and the FIFO has space; the
//   pulse and its coordinates appear in the following cycle. ray_valid_in
//   is a one-cycle pulse with no backpressure; ray_valid_out follows one
//   cycle later.
//
//   Ports:
//     clk_in, rst_n_in          - clock, synchronous active-low reset
//     frame_start_in            - start one frame (honoured only in IDLE)
//     cam_forward_in            - camera forward, latched at frame start
//     gen_ready_in              - generator can take a pixel
//     gen_valid_out, gen_hcount_out, gen_vcount_out, gen_cam_forward_out
//                               - issue pulse and its payload
//     ray_valid_in, ray_direction_in
//                               - generator result
//     ray_valid_out, ray_hcount_out, ray_vcount_out, ray_direction_out
//                               - tagged ray to the marcher
//     frame_busy_out            - FSM not in IDLE
//     frame_done_out            - one-cycle pulse at frame completion
//     error_out                 - sticky: result arrived with FIFO empty
//     dbg_state_out             - current FSM state
//
//   Optional feature INTERLACE_EN: when defined, each frame issues only the
//   rows whose parity matches a field bit that toggles on every completed
//   frame.
// ---------------------------------------------------------------------------
module pixel_dispatcher
    import pixel_dispatcher_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
    parameter int H_BITS         = `H_BITS,
    parameter int V_BITS         = `V_BITS,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              frame_start_in,
    input  vec3               cam_forward_in,
    input  logic              gen_ready_in,
    output logic              gen_valid_out,
    output logic [H_BITS-1:0] gen_hcount_out,
    output logic [V_BITS-1:0] gen_vcount_out,
    output vec3               gen_cam_forward_out,
    input  logic              ray_valid_in,
    input  vec3               ray_direction_in,
    output logic              ray_valid_out,
    output logic [H_BITS-1:0] ray_hcount_out,
    output logic [V_BITS-1:0] ray_vcount_out,
    output vec3               ray_direction_out,
    output logic              frame_busy_out,
    output logic              frame_done_out,
    output logic              error_out,
    output state_t            dbg_state_out
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TAG_W = H_BITS + V_BITS;

`ifdef INTERLACE_EN
    localparam int V_STEP = 2;
`else
    localparam int V_STEP = 1;
`endif

    localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
    // Any row at or beyond this one is the final row of the frame (for the
    // interlaced build this covers both parities with one compare).
    localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - V_STEP);

    state_t            r_state;
    state_t            w_state_next;

    logic [H_BITS-1:0] r_h;
    logic [V_BITS-1:0] r_v;
    logic              r_gen_valid;
    logic [H_BITS-1:0] r_gen_h;
    logic [V_BITS-1:0] r_gen_v;
    vec3               r_cam;
    logic              r_ray_valid;
    logic [H_BITS-1:0] r_ray_h;
    logic [V_BITS-1:0] r_ray_v;
    vec3               r_ray_dir;
    logic              r_done;
    logic              r_error;

    logic              w_start;
    logic              w_issue;
    logic              w_done;
    logic              w_last_pixel;
    logic              w_pop;
    logic [V_BITS-1:0] w_first_row;

    logic [TAG_W-1:0]  w_head;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [CNT_W-1:0]  w_fifo_count;

`ifdef INTERLACE_EN
    logic              r_field;
    assign w_first_row = V_BITS'(r_field);
`else
    assign w_first_row = '0;
`endif

    assign w_last_pixel = (r_h == H_LAST) && (r_v >= V_LAST);
    assign w_pop        = ray_valid_in && !w_fifo_empty;

    // ---------------- FSM: next state and strobes ----------------
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_issue      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start_in) begin
                    w_start      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // r_gen_valid blocks back-to-back issues.
                if (gen_ready_in && !r_gen_valid && !w_fifo_full) begin
                    w_issue = 1'b1;
                    if (w_last_pixel) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // A result arriving now would be a pop into an empty FIFO;
                // wait it out so the done pulse never races a result.
                if ((w_fifo_count == '0) && !ray_valid_in) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- State and datapath registers ----------------
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state     <= ST_IDLE;
            r_h         <= '0;
            r_v         <= '0;
            r_gen_valid <= 1'b0;
            r_gen_h     <= '0;
            r_gen_v     <= '0;
            r_cam       <= '0;
            r_ray_valid <= 1'b0;
            r_ray_h     <= '0;
            r_ray_v     <= '0;
            r_ray_dir   <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef INTERLACE_EN
            r_field     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_done      <= w_done;
            r_gen_valid <= w_issue;

            if (w_start) begin
                r_cam <= cam_forward_in;
                r_h   <= '0;
                r_v   <= w_first_row;
            end else if (w_issue) begin
                r_gen_h <= r_h;
                r_gen_v <= r_v;
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    r_v <= r_v + V_BITS'(V_STEP);
                end else begin
                    r_h <= r_h + H_BITS'(1);
                end
            end

            r_ray_valid <= w_pop;
            if (w_pop) begin
                r_ray_h   <= w_head[TAG_W-1:V_BITS];
                r_ray_v   <= w_head[V_BITS-1:0];
                r_ray_dir <= ray_direction_in;
            end

            if (ray_valid_in && w_fifo_empty) begin
                r_error <= 1'b1;
            end

`ifdef INTERLACE_EN
            if (w_done) begin
                r_field <= ~r_field;
            end
`endif
        end
    end

    pixel_dispatcher_coord_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (TAG_W)
    ) u_coord_fifo (
        .i_clk       (clk_in),
        .i_rst_n     (rst_n_in),
        .i_push      (w_issue),
        .i_push_data ({r_h, r_v}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (w_fifo_count)
    );

    assign gen_valid_out       = r_gen_valid;
    assign gen_hcount_out      = r_gen_h;
    assign gen_vcount_out      = r_gen_v;
    assign gen_cam_forward_out = r_cam;
    assign ray_valid_out       = r_ray_valid;
    assign ray_hcount_out      = r_ray_h;
    assign ray_vcount_out      = r_ray_v;
    assign ray_direction_out   = r_ray_dir;
    assign frame_busy_out      = (r_state != ST_IDLE);
    assign frame_done_out      = r_done;
    assign error_out           = r_error;
    assign dbg_state_out       = r_state;

endmodule

// File: tb/tb_pixel_dispatcher.sv
module tb_pixel_dispatcher;
  import pixel_dispatcher_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int D  = 4;
  localparam int HB = 4;
  localparam int VB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic frame_start = 1'b0;
  vec3 cam_fwd = '0;
  logic gen_ready;
  logic gen_valid_out;
  logic [HB-1:0] gen_hcount_out;
  logic [VB-1:0] gen_vcount_out;
  vec3 gen_cam_forward_out;
  logic ray_valid_in;
  vec3 ray_dir_in;
  logic ray_valid_out;
  logic [HB-1:0] ray_hcount_out;
  logic [VB-1:0] ray_vcount_out;
  vec3 ray_direction_out;
  logic frame_busy_out, frame_done_out, error_out;
  state_t dbg_state_out;

  // generator sources: automatic (fixed latency) or manual
  logic gen_auto = 1'b0;
  logic auto_ready, auto_valid;
  logic [47:0] auto_dir;
  logic man_ready = 1'b0;
  logic man_valid = 1'b0;
  logic [47:0] man_dir = '0;

  assign gen_ready    = gen_auto ? auto_ready : man_ready;
  assign ray_valid_in = auto_valid | man_valid;
  assign ray_dir_in   = auto_valid ? auto_dir : man_dir;

  pixel_dispatcher #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .H_BITS        (HB),
    .V_BITS        (VB),
    .FIFO_DEPTH    (D)
  ) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .frame_start_in     (frame_start),
    .cam_forward_in     (cam_fwd),
    .gen_ready_in       (gen_ready),
    .gen_valid_out      (gen_valid_out),
    .gen_hcount_out     (gen_hcount_out),
    .gen_vcount_out     (gen_vcount_out),
    .gen_cam_forward_out(gen_cam_forward_out),
    .ray_valid_in       (ray_valid_in),
    .ray_direction_in   (ray_dir_in),
    .ray_valid_out      (ray_valid_out),
    .ray_hcount_out     (ray_hcount_out),
    .ray_vcount_out     (ray_vcount_out),
    .ray_direction_out  (ray_direction_out),
    .frame_busy_out     (frame_busy_out),
    .frame_done_out     (frame_done_out),
    .error_out          (error_out),
    .dbg_state_out      (dbg_state_out)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] make_dir(input logic [7:0] hv);
    return {16'h1000 + {12'h0, hv[7:4]}, 16'h2000 + {12'h0, hv[3:0]}, 16'h3C3C};
  endfunction

  // ---------------- monitor (negedge sampling) ----------------
  logic [7:0]  iss_q[$];
  logic [55:0] out_q[$];
  int cyc = 0, last_out_cyc = 0, done_cyc = 0;
  int done_cnt = 0, done_busy_bad = 0, b2b = 0;
  logic prev_gv = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_gv <= gen_valid_out;
    if (gen_valid_out) begin
      iss_q.push_back({gen_hcount_out, gen_vcount_out});
      if (prev_gv) b2b <= b2b + 1;
    end
    if (ray_valid_out) begin
      out_q.push_back({ray_hcount_out, ray_vcount_out, ray_direction_out});
      last_out_cyc <= cyc;
    end
    if (frame_done_out) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (frame_busy_out) done_busy_bad <= done_busy_bad + 1;
    end
  end

  // ---------------- automatic generator: 7-cycle latency ----------------
  initial begin
    auto_ready = 1'b0;
    auto_valid = 1'b0;
    auto_dir   = '0;
    forever begin
      @(negedge clk);
      auto_valid = 1'b0;
      if (!gen_auto) begin
        auto_ready = 1'b0;
      end else if (gen_valid_out) begin
        auto_ready = 1'b0;
        auto_dir   = make_dir({gen_hcount_out, gen_vcount_out});
        repeat (6) @(negedge clk);
        auto_valid = 1'b1;
        auto_ready = 1'b1;
      end else begin
        auto_ready = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int ret_idx = 0;
`ifdef INTERLACE_EN
  int b_field = 0;
`endif

  task automatic start_frame(input logic [47:0] cam);
    @(negedge clk);
    frame_start = 1'b1;
    cam_fwd     = cam;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic return_raw(input logic [47:0] dir);
    @(negedge clk);
    man_valid = 1'b1;
    man_dir   = dir;
    @(negedge clk);
    man_valid = 1'b0;
  endtask

  task automatic return_one();
    return_raw(make_dir(iss_q[ret_idx]));
    ret_idx++;
  endtask

  task automatic wait_iss(input int n, input int budget);
    int b = budget;
    while (iss_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("wait_iss", 64'(iss_q.size() >= n), 1);
  endtask

  task automatic wait_done(input int db, input int budget);
    int b = budget;
    while (done_cnt == db && b > 0) begin
      @(negedge clk);
      b--;
    end
    check("wait_done", 64'(done_cnt > db), 1);
  endtask

  task automatic drain_manual(input int db);
    int b = 2000;
    while (done_cnt == db && b > 0) begin
      if (ret_idx < iss_q.size()) return_one();
      else @(negedge clk);
      b--;
    end
    check("drain_done", 64'(done_cnt > db), 1);
  endtask

  // Compare one completed frame against the bench's own raster model.
  task automatic check_frame(input int ib, input int ob, input int db, input logic exp_err);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_i;
    logic [55:0] got_o;
    exp_q = {};
    for (int v = 0; v < H; v++) begin
`ifdef INTERLACE_EN
      if ((v % 2) != b_field) continue;
`endif
      for (int h = 0; h < W; h++) exp_q.push_back({4'(h), 4'(v)});
    end
    check("iss_count", 64'(iss_q.size() - ib), 64'(exp_q.size()));
    check("out_count", 64'(out_q.size() - ob), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got_i = (ib + i < iss_q.size()) ? iss_q[ib + i] : 8'hFF;
      check($sformatf("iss_coord%0d", i), got_i, exp_q[i]);
      got_o = (ob + i < out_q.size()) ? out_q[ob + i] : '1;
      check($sformatf("out_coord%0d", i), got_o[55:48], exp_q[i]);
      check($sformatf("out_dir%0d", i), got_o[47:0], make_dir(exp_q[i]));
    end
    check("done_pulses", 64'(done_cnt - db), 1);
    check("done_after_out", 64'(done_cyc), 64'(last_out_cyc + 1));
    check("done_busy_low", 64'(done_busy_bad), 0);
    check("no_back_to_back", 64'(b2b), 0);
    check("error_flag", error_out, exp_err);
    check("idle_after", dbg_state_out, ST_IDLE);
`ifdef INTERLACE_EN
    b_field = 1 - b_field;
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int ib, ob, db, flen, n;
`ifdef INTERLACE_EN
    flen = W * H / 2;
`else
    flen = W * H;
`endif

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_gen_valid", gen_valid_out, 0);
    check("rst_ray_valid", ray_valid_out, 0);
    check("rst_busy", frame_busy_out, 0);
    check("rst_done", frame_done_out, 0);
    check("rst_error", error_out, 0);
    check("rst_cam", gen_cam_forward_out, 0);
    check("rst_state", dbg_state_out, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // full frame with the fixed-latency generator
    gen_auto = 1'b1;
    repeat (2) @(negedge clk);
    ib = iss_q.size(); ob = out_q.size(); db = done_cnt;
    start_frame(48'h0001_0002_0003);
    cam_fwd = 48'h7777_8888_9999;
    check("busy_t1", frame_busy_out, 1);
    check("state_t1", dbg_state_out, ST_ISSUE);
    @(negedge clk);
    check("first_issue_t2", gen_valid_out, 1);
    check("first_h", gen_hcount_out, 0);
    check("first_v", gen_vcount_out, 0);
    wait_done(db, 600);
    check("cam_held", gen_cam_forward_out, 48'h0001_0002_0003);
    repeat (5) @(negedge clk);
    check_frame(ib, ob, db, 1'b0);
    gen_auto = 1'b0;
    repeat (3) @(negedge clk);

    // backpressure: ready low for 20 cycles after 3 issues
    man_ready = 1'b1;
    ret_idx = iss_q.size();
    ib = iss_q.size(); ob = out_q.size(); db = done_cnt;
    start_frame(48'h0004_0005_0006);
    wait_iss(ib + 3, 100);
    man_ready = 1'b0;
    start_frame(48'hDEAD_BEEF_0000);   // ignored outside IDLE
    repeat (18) @(negedge clk);
    check("bp_no_issue", 64'(iss_q.size() - ib), 3);
    check("bp_cam_kept", gen_cam_forward_out, 48'h0004_0005_0006);
    man_ready = 1'b1;
    drain_manual(db);
    repeat (5) @(negedge clk);
    check_frame(ib, ob, db, 1'b0);

    // FIFO full: always ready, results withheld
    ret_idx = iss_q.size();
    ib = iss_q.size(); ob = out_q.size(); db = done_cnt;
    start_frame(48'h0010_0020_0030);
    repeat (30) @(negedge clk);
    check("full_issues", 64'(iss_q.size() - ib), 4);
    check("full_state", dbg_state_out, (flen > 4) ? ST_ISSUE : ST_DRAIN);
    return_one();
    repeat (20) @(negedge clk);
    n = (flen > 4) ? 5 : 4;
    check("full_release_issue", 64'(iss_q.size() - ib), 64'(n));
    check("full_release_out", 64'(out_q.size() - ob), 1);
    drain_manual(db);
    repeat (5) @(negedge clk);
    check_frame(ib, ob, db, 1'b0);

    // spurious result in IDLE with FIFO empty
    ob = out_q.size();
    return_raw(48'h1234_5678_9ABC);
    check("spur_error", error_out, 1);
    check("spur_no_out", ray_valid_out, 0);
    repeat (5) @(negedge clk);
    check("spur_error_sticky", error_out, 1);
    check("spur_out_count", 64'(out_q.size() - ob), 0);

    // reset mid-frame after 3 issues
    ib = iss_q.size();
    start_frame(48'h0A0A_0B0B_0C0C);
    wait_iss(ib + 3, 100);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_gen_valid", gen_valid_out, 0);
    check("mrst_hcount", gen_hcount_out, 0);
    check("mrst_busy", frame_busy_out, 0);
    check("mrst_state", dbg_state_out, ST_IDLE);
    check("mrst_cam", gen_cam_forward_out, 0);
    check("mrst_error", error_out, 0);
    check("mrst_ray_valid", ray_valid_out, 0);
    rst_n = 1'b1;
`ifdef INTERLACE_EN
    b_field = 0;
`endif
    @(negedge clk);
    ob = out_q.size();
    return_raw(make_dir(iss_q[ib]));   // stale result after reset
    check("stale_error", error_out, 1);
    check("stale_no_out", 64'(out_q.size() - ob), 0);
    ret_idx = iss_q.size();
    ib = iss_q.size(); ob = out_q.size(); db = done_cnt;
    start_frame(48'h0D0D_0E0E_0F0F);
    cam_fwd = '0;
    wait_iss(ib + 1, 20);
    check("restart_coord", iss_q[ib], 8'h00);
    check("restart_cam", gen_cam_forward_out, 48'h0D0D_0E0E_0F0F);
    drain_manual(db);
    repeat (5) @(negedge clk);
    check_frame(ib, ob, db, 1'b1);
    man_ready = 1'b0;

`ifdef INTERLACE_EN
    // two consecutive interlaced frames: field parity alternates
    gen_auto = 1'b1;
    repeat (2) @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      ib = iss_q.size(); ob = out_q.size(); db = done_cnt;
      start_frame(48'h0100_0200_0300);
      wait_done(db, 600);
      repeat (5) @(negedge clk);
      check_frame(ib, ob, db, 1'b1);
    end
    gen_auto = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: observed time limit reached, expected normal finish");
    $fatal(1, "simulation time limit");
  end

endmodule
